// File: rtl/ksa_round_key_sequencer.sv
// KSA round-key sequencer: latches a master key, generates NUM_ROUNDS round keys
// one per cycle into a buffer, and serves them through a 1-cycle registered read port.

module ksa #(
    parameter int unsigned KEY_W   = 64,
    parameter int unsigned RK_W    = 32,
    parameter int unsigned ROUND_W = 5
) (
    input  logic [KEY_W-1:0]   key,
    input  logic [ROUND_W-1:0] round,
    output logic [RK_W-1:0]    new_key
);
    logic unused_key_hi;

    assign new_key       = key[RK_W-1:0] ^ RK_W'(round);
    assign unused_key_hi = ^key[KEY_W-1:RK_W];
endmodule

module ksa_round_key_sequencer #(
    parameter int unsigned KEY_W      = 64,
    parameter int unsigned RK_W       = 32,
    parameter int unsigned NUM_ROUNDS = 31,
    parameter int unsigned ROUND_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_W-1:0]   key_in,
    output logic               busy,
    output logic               done,
    output logic               keys_ready,
    input  logic               rd_en,
    input  logic [ROUND_W-1:0] rd_round,
    output logic [RK_W-1:0]    rd_data,
    output logic               rd_valid
);
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [ROUND_W-1:0] wcount_q, wcount_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               keys_ready_q, keys_ready_d;
    logic               wr_en;
    logic [RK_W-1:0]    new_key;
    logic [RK_W-1:0]    buf_q [NUM_ROUNDS];
    logic [RK_W-1:0]    rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_hit;

    ksa #(
        .KEY_W   (KEY_W),
        .RK_W    (RK_W),
        .ROUND_W (ROUND_W)
    ) u_ksa (
        .key     (key_q),
        .round   (round_q),
        .new_key (new_key)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            round_q      <= '0;
            wcount_q     <= '0;
            key_q        <= '0;
            keys_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            wcount_q     <= wcount_d;
            key_q        <= key_d;
            keys_ready_q <= keys_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        wcount_d     = wcount_q;
        key_d        = key_q;
        keys_ready_d = keys_ready_q;
        wr_en        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d        = key_in;
                    round_d      = ROUND_W'(1);
                    wcount_d     = '0;
                    keys_ready_d = 1'b0;
                    state_d      = GEN;
                end
            end
            GEN: begin
                busy     = 1'b1;
                wr_en    = 1'b1;
                wcount_d = round_q;
                if (round_q == LAST_ROUND) state_d = DONE;
                else                       round_d = round_q + 1'b1;
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                keys_ready_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer is not reset; wcount_q alone decides which entries are readable.
    always_ff @(posedge clk) begin
        if (reset && wr_en) buf_q[round_q - 1'b1] <= new_key;
    end

    // Uses the pre-edge count, so a round written this cycle is not yet readable.
    assign rd_hit = (rd_round != '0) && (rd_round <= wcount_q);

    always_comb begin
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_valid_d = rd_hit;
            rd_data_d  = rd_hit ? buf_q[rd_round - 1'b1] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign keys_ready = keys_ready_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
endmodule

// File: tb/tb_ksa_round_key_sequencer.sv
// Directed self-checking bench for ksa_round_key_sequencer (stub KSA: key[31:0] ^ round).

module tb_ksa_round_key_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] key_in = '0;
    logic        busy, done, keys_ready;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_round = '0;
    logic [31:0] rd_data;
    logic        rd_valid;

    int checks = 0;
    int errors = 0;

    ksa_round_key_sequencer #(
        .KEY_W      (64),
        .RK_W       (32),
        .NUM_ROUNDS (31),
        .ROUND_W    (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_ready (keys_ready),
        .rd_en      (rd_en),
        .rd_round   (rd_round),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rnd;
        logic        exp_v;
        logic [31:0] exp_d;
    } rd_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] k);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic read_chk(input string name, input logic [4:0] r,
                            input logic exp_v, input logic [31:0] exp_d);
        rd_en    = 1'b1;
        rd_round = r;
        tick();
        rd_en    = 1'b0;
        chk({name, "_valid"}, 64'(rd_valid), 64'(exp_v));
        chk({name, "_data"}, 64'(rd_data), 64'(exp_d));
    endtask

    initial begin
        rd_vec_t     vecs [7];
        int          cyc;
        logic [63:0] ka, kb, kc, kd;
        logic [31:0] hold;

        vecs[0] = '{5'd1,  1'b1, 32'h89AB_CDEE};
        vecs[1] = '{5'd16, 1'b1, 32'h89AB_CDFF};
        vecs[2] = '{5'd31, 1'b1, 32'h89AB_CDF0};
        vecs[3] = '{5'd0,  1'b0, 32'h0000_0000};
        vecs[4] = '{5'd5,  1'b1, 32'h89AB_CDEA};
        vecs[5] = '{5'd30, 1'b1, 32'h89AB_CDF1};
        vecs[6] = '{5'd0,  1'b0, 32'h0000_0000};
        vecs[6].rnd = 5'd32 - 5'd32 + 5'd31 + 5'd1; // wraps to 0 in 5 bits

        // Reset
        reset = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_keys_ready", 64'(keys_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        reset = 1'b1;
        tick();

        // Full schedule
        do_start(64'h0123_4567_89AB_CDEF);
        chk("gen_busy", 64'(busy), 64'd1);
        chk("gen_keys_ready_clr", 64'(keys_ready), 64'd0);
        wait_done(cyc);
        chk("done_latency", 64'(cyc), 64'd31);
        chk("done_busy", 64'(busy), 64'd1);
        tick();
        chk("done_pulse_end", 64'(done), 64'd0);
        chk("keys_ready_set", 64'(keys_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 7; i++)
            read_chk($sformatf("vec%0d_r%0d", i, vecs[i].rnd), vecs[i].rnd, vecs[i].exp_v, vecs[i].exp_d);

        // rd_en low: valid drops, data holds
        read_chk("pre_hold", 5'd16, 1'b1, 32'h89AB_CDFF);
        hold = rd_data;
        tick();
        chk("hold_valid", 64'(rd_valid), 64'd0);
        chk("hold_data", 64'(rd_data), 64'(32'h89AB_CDFF));

        // Start while busy is ignored
        ka = 64'hFEDC_BA98_7654_3210;
        kb = 64'h1111_2222_3333_4444;
        do_start(ka);
        for (int i = 0; i < 9; i++) tick();
        start  = 1'b1;
        key_in = kb;
        tick();
        start  = 1'b0;
        wait_done(cyc);
        chk("busy_start_latency", 64'(cyc), 64'd21);
        tick();
        for (int r = 1; r <= 31; r++)
            read_chk($sformatf("ign_r%0d", r), 5'(r), 1'b1, ka[31:0] ^ 32'(r));

        // Streaming read of round 5 during generation
        kc = 64'hA5A5_5A5A_C3C3_3C3C;
        rd_en    = 1'b1;
        rd_round = 5'd5;
        start    = 1'b1;
        key_in   = kc;
        tick();
        start    = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("stream_v_k%0d", k), 64'(rd_valid), 64'(k >= 6));
            chk($sformatf("stream_d_k%0d", k), 64'(rd_data),
                (k >= 6) ? 64'(kc[31:0] ^ 32'd5) : 64'd0);
        end
        rd_en = 1'b0;
        wait_done(cyc);
        chk("stream_done_seen", 64'(cyc > 0), 64'd1);
        tick();

        // Reset at round 20, then restart
        do_start(64'h0F0F_F0F0_1234_5678);
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_keys_ready", 64'(keys_ready), 64'd0);
        read_chk("abort_r3", 5'd3, 1'b0, 32'd0);

        kd = 64'h7777_8888_DEAD_BEEF;
        do_start(kd);
        wait_done(cyc);
        chk("restart_latency", 64'(cyc), 64'd31);
        tick();
        chk("restart_keys_ready", 64'(keys_ready), 64'd1);
        read_chk("restart_r3", 5'd3, 1'b1, kd[31:0] ^ 32'd3);
        read_chk("restart_r20", 5'd20, 1'b1, kd[31:0] ^ 32'd20);
        read_chk("restart_r31", 5'd31, 1'b1, kd[31:0] ^ 32'd31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
